// File: rtl/rv_shift_pkg.sv
// Package for the rv_shift_unit slice.
//   - shift_op_e : operation encodings presented on in_op.
//   - XLEN_DEFAULT / SHAMT_W() : default datapath width and shift-amount width.
//   - is_right_op / is_rotate_op / is_legal_op : op classification helpers.
// Optional feature macro: RV_SHIFT_ROTATE_EN (makes ROL/ROR legal).
package rv_shift_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b011,
    OP_ROL = 3'b100,
    OP_ROR = 3'b101
  } shift_op_e;

  function automatic int SHAMT_W(input int xlen);
    return $clog2(xlen);
  endfunction

  // Right-going ops are executed as left shifts on the bit-reversed operand.
  function automatic logic is_right_op(input logic [2:0] op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  function automatic logic is_rotate_op(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

  function automatic logic is_legal_op(input logic [2:0] op);
`ifdef RV_SHIFT_ROTATE_EN
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
           (op == OP_ROL) || (op == OP_ROR);
`else
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`endif
  endfunction

endpackage

// File: rtl/shift_onehot_dec.sv
// shift_onehot_dec: combinational split of a shift amount into one-hot selects.
//   shamt    in  $clog2(XLEN)  shift amount
//   byte_sel out XLEN/8        one-hot byte-lane select from shamt[MSB:3]
//   bit_sel  out 8             one-hot bit select from shamt[2:0]
// Exactly one bit is set in each output; these drive the select inputs of
// the 8-bit diagonal shift slices in rv_shift_unit.
module shift_onehot_dec
  import rv_shift_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [SHAMT_W(XLEN)-1:0] shamt,
  output logic [XLEN/8-1:0]        byte_sel,
  output logic [7:0]               bit_sel
);

  localparam int SW    = SHAMT_W(XLEN);
  localparam int LANES = XLEN / 8;

  assign bit_sel = 8'b1 << shamt[2:0];

  generate
    if (LANES == 1) begin : g_single_lane
      // A single byte lane has no byte-level shift; the select is constant.
      assign byte_sel = 1'b1;
    end else begin : g_multi_lane
      assign byte_sel = LANES'(1) << shamt[SW-1:3];
    end
  endgenerate

endmodule

// File: rtl/rv_shift_unit.sv
// rv_shift_unit: two-stage pipelined RV32I shift unit (SLL/SRL/SRA, optional
// ROL/ROR under macro RV_SHIFT_ROTATE_EN). Fixed two-cycle latency, one op
// per cycle while writeback keeps out_ready high.
//   clk, rst_n                    clock / async active-low reset
//   in_valid, in_ready            issue handshake
//   in_op, in_data, in_shamt      operation, operand rs1, shift amount
//   in_tag                        opaque tag carried with the op
//   out_valid, out_ready          writeback handshake
//   out_data, out_tag, out_err    result, tag, unsupported-op flag
// Stage 1 normalises every op to a left shift (bit-reversing right-going
// operands), captures the fill bit and the one-hot shift selects.
// Stage 2 runs the byte then bit diagonal shift, reverses back and registers.
module rv_shift_unit
  import rv_shift_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [XLEN-1:0]          in_data,
  input  logic [SHAMT_W(XLEN)-1:0] in_shamt,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err
);

  localparam int LANES = XLEN / 8;

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction

  // ---------------------------------------------------------------- state
  logic             s1_v_q, s1_v_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [XLEN-1:0]  s1_data_q, s1_data_d;
  logic             s1_fill_q, s1_fill_d;
  logic [LANES-1:0] s1_byte_sel_q, s1_byte_sel_d;
  logic [7:0]       s1_bit_sel_q, s1_bit_sel_d;

  logic             s2_v_q, s2_v_d;
  logic [XLEN-1:0]  s2_data_q, s2_data_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_err_q, s2_err_d;

  // ------------------------------------------------------------ handshake
  logic s1_adv;
  assign s1_adv   = !s2_v_q || out_ready;
  assign in_ready = !s1_v_q || s1_adv;

  // -------------------------------------------------------------- decode
  logic [LANES-1:0] dec_byte_sel;
  logic [7:0]       dec_bit_sel;

  shift_onehot_dec #(.XLEN(XLEN)) u_dec (
    .shamt    (in_shamt),
    .byte_sel (dec_byte_sel),
    .bit_sel  (dec_bit_sel)
  );

  // ------------------------------------------------------- stage 1 next
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    s1_v_d        = s1_v_q;
    s1_op_d       = s1_op_q;
    s1_tag_d      = s1_tag_q;
    s1_data_d     = s1_data_q;
    s1_fill_d     = s1_fill_q;
    s1_byte_sel_d = s1_byte_sel_q;
    s1_bit_sel_d  = s1_bit_sel_q;
    if (in_ready) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_op_d       = in_op;
        s1_tag_d      = in_tag;
        s1_data_d     = is_right_op(in_op) ? bit_rev(in_data) : in_data;
        // Fill comes from the original MSB, before any reversal.
        s1_fill_d     = (in_op == OP_SRA) ? in_data[XLEN-1] : 1'b0;
        s1_byte_sel_d = dec_byte_sel;
        s1_bit_sel_d  = dec_bit_sel;
      end
    end
  end

  // ---------------------------------------------------- stage 2 datapath
  // The operand sits in the upper half of a 2*XLEN word; the lower half holds
  // what should enter the vacated LSBs (fill bits, or the operand itself for
  // rotates). After the left shift the upper half is the result.
  logic [XLEN-1:0]   low_half;
  logic [2*XLEN-1:0] wide, byte_shifted, bit_shifted;
  logic [XLEN-1:0]   shifted, result;
  logic              legal;

  always_comb begin
`ifdef RV_SHIFT_ROTATE_EN
    low_half = is_rotate_op(s1_op_q) ? s1_data_q : {XLEN{s1_fill_q}};
`else
    low_half = {XLEN{s1_fill_q}};
`endif
    wide = {s1_data_q, low_half};

    // Diagonal slices: each one-hot select gates one shifted copy.
    byte_shifted = '0;
    for (int k = 0; k < LANES; k++)
      if (s1_byte_sel_q[k]) byte_shifted = byte_shifted | (wide << (8 * k));

    bit_shifted = '0;
    for (int b = 0; b < 8; b++)
      if (s1_bit_sel_q[b]) bit_shifted = bit_shifted | (byte_shifted << b);

    shifted = bit_shifted[2*XLEN-1:XLEN];
    result  = is_right_op(s1_op_q) ? bit_rev(shifted) : shifted;
    legal   = is_legal_op(s1_op_q);
  end

  // ------------------------------------------------------- stage 2 next
  always_comb begin
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_tag_d  = s2_tag_q;
    s2_err_d  = s2_err_q;
    if (s1_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_data_d = legal ? result : '0;
        s2_tag_d  = s1_tag_q;
        s2_err_d  = !legal;
      end
    end
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload registers are reset as well, not only the valids,
      // because out_data/out_tag/out_err must read 0 straight out of reset.
      s1_v_q        <= 1'b0;
      s1_op_q       <= '0;
      s1_tag_q      <= '0;
      s1_data_q     <= '0;
      s1_fill_q     <= 1'b0;
      s1_byte_sel_q <= '0;
      s1_bit_sel_q  <= '0;
      s2_v_q        <= 1'b0;
      s2_data_q     <= '0;
      s2_tag_q      <= '0;
      s2_err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_v_q        <= s1_v_d;
      s1_op_q       <= s1_op_d;
      s1_tag_q      <= s1_tag_d;
      s1_data_q     <= s1_data_d;
      s1_fill_q     <= s1_fill_d;
      s1_byte_sel_q <= s1_byte_sel_d;
      s1_bit_sel_q  <= s1_bit_sel_d;
      s2_v_q        <= s2_v_d;
      s2_data_q     <= s2_data_d;
      s2_tag_q      <= s2_tag_d;
      s2_err_q      <= s2_err_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;
  assign out_err   = s2_err_q;

endmodule

// File: tb/tb_rv_shift_unit.sv
// Self-checking bench for rv_shift_unit (XLEN=32, TAG_W=5). A scoreboard of
// expected results, computed with plain shift arithmetic, is filled on every
// input transfer and drained on every output transfer.
module tb_rv_shift_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  rv_shift_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] d,
                                 input logic [4:0] s, input logic [4:0] t);
    exp_t        e;
    logic [63:0] dd;
    dd     = {d, d};
    e.tag  = t;
    e.err  = 1'b0;
    e.data = '0;
    case (op)
      3'b000: e.data = d << s;
      3'b001: e.data = d >> s;
      3'b011: e.data = $signed(d) >>> s;
`ifdef RV_SHIFT_ROTATE_EN
      3'b100: begin dd = dd << s; e.data = dd[63:32]; end
      3'b101: begin dd = dd >> s; e.data = dd[31:0];  end
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // ------------------------------------------------------ monitor (negedge)
  exp_t        mon_e;
  bit          hold = 1'b0;
  logic [31:0] h_data;
  logic [4:0]  h_tag;
  logic        h_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, h_data);
        check("hold_tag", out_tag, h_tag);
        check("hold_err", out_err, h_err);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1'b1, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_tag", out_tag, mon_e.tag);
          check("out_err", out_err, mon_e.err);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_op, in_data, in_shamt, in_tag));
      hold   = out_valid && !out_ready;
      h_data = out_data;
      h_tag  = out_tag;
      h_err  = out_err;
    end
  end

  // ---------------------------------------------------------------- tasks
  task automatic issue(input logic [2:0] op, input logic [31:0] d,
                       input logic [4:0] s, input logic [4:0] t);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    in_tag   = t;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("issue_timeout", 1'b0, 1'b1);
        break;
      end
      @(posedge clk); #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    int n;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ------------------------------------------------------------- stimulus
  logic [2:0]  t4_op[4]   = '{3'b000, 3'b001, 3'b011, 3'b000};
  logic [31:0] t4_data[4] = '{32'h1234_5678, 32'h8765_4321, 32'hF000_000F, 32'h0000_00FF};
  logic [4:0]  t4_sh[4]   = '{5'd3, 5'd7, 5'd9, 5'd24};
  logic [2:0]  t3_ops[8]  = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b010, 3'b110, 3'b111};

  initial begin
    int idx;
    int acc;

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_tag", out_tag, 5'd0);
    check("rst_out_err", out_err, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Test 1: SLL latency, issued after edge E0 -> valid after E2
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 3'b000;
    in_data   = 32'h0000_00F1;
    in_shamt  = 5'd4;
    in_tag    = 5'd3;
    check("lat_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_e1_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_e2_valid", out_valid, 1'b1);
    check("lat_e2_data", out_data, 32'h0000_0F10);
    check("lat_e2_tag", out_tag, 5'd3);
    check("lat_e2_err", out_err, 1'b0);
    drain();

    // Test 2: arithmetic/logical right boundaries
    issue(3'b011, 32'h8000_0000, 5'd31, 5'd1);
    issue(3'b001, 32'h8000_0000, 5'd31, 5'd2);
    issue(3'b011, 32'h7000_0000, 5'd28, 5'd3);
    issue(3'b000, 32'h0000_0001, 5'd31, 5'd4);
    issue(3'b000, 32'hFFFF_FFFF, 5'd31, 5'd5);
    drain();

    // Test 3: shamt 0 on every op code, plus undefined codes
    for (int i = 0; i < 8; i++) issue(t3_ops[i], 32'hDEAD_BEEF, 5'd0, 5'(i + 8));
    issue(3'b010, 32'hDEAD_BEEF, 5'd5, 5'd20);
    drain();

    // Test 5: rotates (result depends on build)
    issue(3'b101, 32'h0000_0001, 5'd1, 5'd21);
    issue(3'b100, 32'h8000_0001, 5'd1, 5'd22);
    issue(3'b101, 32'h1234_5678, 5'd12, 5'd23);
    drain();

    // Test 4: stall with back-to-back issue
    out_ready = 1'b0;
    idx = 0;
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_op    = t4_op[idx];
      in_data  = t4_data[idx];
      in_shamt = t4_sh[idx];
      in_tag   = 5'(idx + 24);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
      idx = acc;
    end
    in_valid = 1'b0;
    check("stall_accepts", acc, 2);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int i = 2; i < 4; i++) issue(t4_op[i], t4_data[i], t4_sh[i], 5'(i + 24));
    drain();

    // Randomized traffic with random writeback back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++)
      issue(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    drain();

    // Test 6: reset with both stages full
    out_ready = 1'b0;
    issue(3'b000, 32'hA5A5_A5A5, 5'd1, 5'd30);
    issue(3'b001, 32'h5A5A_5A5A, 5'd2, 5'd31);
    check("pre_rst_out_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_data", out_data, 32'h0);
    check("async_rst_tag", out_tag, 5'd0);
    check("async_rst_err", out_err, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("post_rst_in_ready", in_ready, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("post_rst_no_stale", out_valid, 1'b0);
    end

    // One more op after reset proves the pipe still works
    issue(3'b011, 32'h8000_0000, 5'd4, 5'd7);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
